// File: rtl/packet_serializer_pkg.sv
// Shared definitions for the packet serializer: FSM state encoding and
// the helper that turns a packet width into a beat count.
package packet_serializer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/packet_serializer_if.sv
// Handshake bundle for the serializer: the wide packet side
// (access_in/packet_in/wait_out) and the narrow beat side
// (access_out/data_out/first_out/last_out/wait_in).
// The slave modport is the serializer's view; master is the environment's view.
interface packet_serializer_if #(
    parameter int DW = 104,
    parameter int OW = 32
);
    logic          access_in;
    logic [DW-1:0] packet_in;
    logic          wait_out;
    logic          access_out;
    logic [OW-1:0] data_out;
    logic          first_out;
    logic          last_out;
    logic          wait_in;

    modport master (
        output access_in, packet_in, wait_in,
        input  wait_out, access_out, data_out, first_out, last_out
    );

    modport slave (
        input  access_in, packet_in, wait_in,
        output wait_out, access_out, data_out, first_out, last_out
    );
endinterface

// File: rtl/packet_serializer.sv
// Packet serializer: takes one wide packet at a time from the FIFO read side
// and emits it as N narrow beats, LSB first, with the top of the final beat
// zero padded. A new packet can be loaded on the cycle the last beat leaves,
// so a continuous input stream produces a continuous beat stream.
module packet_serializer
    import packet_serializer_pkg::*;
#(
    parameter int DW = 104,
    parameter int OW = 32
) (
    input  logic               clk,
    input  logic               reset,
    packet_serializer_if.slave bus
);

    localparam int N  = ceil_div(DW, OW);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = N * OW;
    localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   beat_q, beat_d;
    logic [SW-1:0]   shreg_q, shreg_d;
    logic            first_q, first_d;
    logic            last_q, last_d;
    logic [SW-1:0]   load_val;

    // Zero-extend the incoming packet so the bits above DW in the last beat read as 0.
    always_comb begin
        load_val = '0;
        load_val[DW-1:0] = bus.packet_in;
    end

    // Next-state logic: load on accept, shift on each accepted beat, reload or idle after the last beat.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        shreg_d = shreg_q;
        case (state_q)
            IDLE: begin
                if (bus.access_in) begin
                    state_d = SEND;
                    beat_d  = '0;
                    shreg_d = load_val;
                end
            end
            SEND: begin
                if (!bus.wait_in) begin
                    if (beat_q != LAST_BEAT) begin
                        shreg_d = shreg_q >> OW;
                        beat_d  = beat_q + CW'(1);
                    end else if (bus.access_in) begin
                        shreg_d = load_val;
                        beat_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        first_d = (state_d == SEND) && (beat_d == '0);
        last_d  = (state_d == SEND) && (beat_d == LAST_BEAT);
    end

    // State registers; reset discards any partially sent packet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            shreg_q <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            shreg_q <= shreg_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    assign bus.access_out = (state_q == SEND);
    assign bus.data_out   = shreg_q[OW-1:0];
    assign bus.first_out  = first_q;
    assign bus.last_out   = last_q;
    assign bus.wait_out   = (state_q == SEND) & ~(last_q & ~bus.wait_in);

endmodule

// File: tb/tb_packet_serializer.sv
// Directed and scoreboard bench for packet_serializer: a 104->32 instance
// (four beats per packet) and a 32->32 instance (single-beat pipeline stage).
module tb_packet_serializer;

    logic clk;
    logic reset;
    int   checkCount;
    int   errorCount;

    packet_serializer_if #(.DW(104), .OW(32)) bus ();
    packet_serializer_if #(.DW(32),  .OW(32)) bus1 ();

    packet_serializer #(.DW(104), .OW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    packet_serializer #(.DW(32), .OW(32)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count a comparison and report it when observed differs from expected.
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive the upstream and downstream inputs of the four-beat instance.
    task automatic applyStimulus(input logic acc, input logic [103:0] pkt, input logic win);
        bus.access_in = acc;
        bus.packet_in = pkt;
        bus.wait_in   = win;
    endtask

    // Advance to just after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Compare the registered beat outputs of the four-beat instance.
    task automatic checkBeat(input string tag, input logic valid, input logic [31:0] data,
                             input logic first, input logic last);
        checkOutput({tag, "_valid"}, bus.access_out, valid);
        checkOutput({tag, "_data"},  bus.data_out,   data);
        checkOutput({tag, "_first"}, bus.first_out,  first);
        checkOutput({tag, "_last"},  bus.last_out,   last);
    endtask

    localparam logic [103:0] PKT_A = 104'h11_22222222_33333333_44444444;
    localparam logic [103:0] PKT_B = 104'hAB_CDEF0123_456789AB_DEADBEEF;
    localparam logic [103:0] PKT_C = 104'h5A_A5A5A5A5_0F0F0F0F_F0F0F0F0;
    localparam logic [103:0] PKT_D = 104'h0D_0C0B0A09_08070605_04030201;
    localparam logic [103:0] PKT_E = 104'hEE_EEEEEEEE_EEEEEEEE_EEEEEEEE;
    localparam int SOAK_PKTS  = 1000;
    localparam int SOAK_LIMIT = 40000;

    initial begin
        logic [31:0]  beats_a [4];
        logic [31:0]  beats_abc [12];
        logic [103:0] pkts_abc [3];
        logic [31:0]  beats_d [4];
        int           stall_beat [8];
        logic         stall_win [8];
        logic         stall_wo [8];
        logic [31:0]  words [5];
        logic [103:0] sent [$];
        logic [127:0] rx;
        logic [127:0] exp_pkt;
        logic         acc, cons;
        int           in_idx, out_idx, rx_beat, rx_count, tx_count, cyc;
        bit           have_pkt;

        checkCount = 0;
        errorCount = 0;

        beats_a   = '{32'h44444444, 32'h33333333, 32'h22222222, 32'h00000011};
        pkts_abc  = '{PKT_A, PKT_B, PKT_C};
        beats_abc = '{32'h44444444, 32'h33333333, 32'h22222222, 32'h00000011,
                      32'hDEADBEEF, 32'h456789AB, 32'hCDEF0123, 32'h000000AB,
                      32'hF0F0F0F0, 32'h0F0F0F0F, 32'hA5A5A5A5, 32'h0000005A};
        beats_d    = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h0000000D};
        stall_beat = '{0, 1, 1, 1, 2, 3, 3, 3};
        stall_win  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        stall_wo   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        words      = '{32'hA0000001, 32'hB0000002, 32'hC0000003, 32'hD0000004, 32'hE0000005};

        // Reset state
        reset = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
        bus1.access_in = 1'b0;
        bus1.packet_in = '0;
        bus1.wait_in   = 1'b0;
        cycle();
        cycle();
        checkBeat("reset", 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("reset_wait_out", bus.wait_out, 1'b0);
        checkOutput("reset_n1_valid", bus1.access_out, 1'b0);
        reset = 1'b0;
        cycle();

        // Single packet, no back-pressure
        $display("[TB] single packet");
        applyStimulus(1'b1, PKT_A, 1'b0);
        #1;
        checkOutput("single_idle_wait_out", bus.wait_out, 1'b0);
        cycle();
        bus.access_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checkBeat($sformatf("single_b%0d", k), 1'b1, beats_a[k], k == 0, k == 3);
            checkOutput($sformatf("single_wait_out_b%0d", k), bus.wait_out, k != 3);
            cycle();
        end
        checkOutput("single_done_valid", bus.access_out, 1'b0);

        // Back-to-back packets with access_in held high
        $display("[TB] back-to-back");
        applyStimulus(1'b1, pkts_abc[0], 1'b0);
        cycle();
        for (int k = 0; k < 12; k++) begin
            if (k % 4 == 0) begin
                if (k / 4 + 1 < 3) bus.packet_in = pkts_abc[k / 4 + 1];
                else               bus.access_in = 1'b0;
            end
            #1;
            checkBeat($sformatf("b2b_b%0d", k), 1'b1, beats_abc[k], k % 4 == 0, k % 4 == 3);
            checkOutput($sformatf("b2b_wait_out_b%0d", k), bus.wait_out, k % 4 != 3);
            cycle();
        end
        checkOutput("b2b_done_valid", bus.access_out, 1'b0);

        // Output stall on beats 1 and 3; a pending packet during the stalled last beat is refused
        $display("[TB] output stall");
        applyStimulus(1'b1, PKT_D, 1'b0);
        cycle();
        for (int i = 0; i < 8; i++) begin
            applyStimulus((i == 5) || (i == 6), (i == 5 || i == 6) ? PKT_E : PKT_D, stall_win[i]);
            #1;
            checkOutput($sformatf("stall_wait_out_c%0d", i), bus.wait_out, stall_wo[i]);
            checkBeat($sformatf("stall_c%0d", i), 1'b1, beats_d[stall_beat[i]],
                      stall_beat[i] == 0, stall_beat[i] == 3);
            cycle();
        end
        applyStimulus(1'b0, '0, 1'b0);
        #1;
        checkOutput("stall_done_valid", bus.access_out, 1'b0);
        cycle();
        checkOutput("stall_no_replay", bus.access_out, 1'b0);

        // Reset in the middle of a packet
        $display("[TB] reset mid-packet");
        applyStimulus(1'b1, PKT_A, 1'b0);
        cycle();
        bus.access_in = 1'b0;
        cycle();
        checkBeat("midrst_b1", 1'b1, 32'h33333333, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        checkBeat("midrst_async", 1'b0, 32'h0, 1'b0, 1'b0);
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            checkOutput($sformatf("midrst_quiet_c%0d", i), bus.access_out, 1'b0);
        end
        applyStimulus(1'b1, PKT_B, 1'b0);
        cycle();
        bus.access_in = 1'b0;
        checkBeat("midrst_new_b0", 1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
        repeat (4) cycle();
        checkOutput("midrst_drained", bus.access_out, 1'b0);

        // Single-beat instance: five words under random output back-pressure
        $display("[TB] single-beat stream");
        in_idx  = 0;
        out_idx = 0;
        bus1.access_in = 1'b1;
        bus1.packet_in = words[0];
        for (cyc = 0; cyc < 200 && out_idx < 5; cyc++) begin
            bus1.wait_in = 1'($urandom_range(0, 1));
            #1;
            acc  = bus1.access_in & ~bus1.wait_out;
            cons = bus1.access_out & ~bus1.wait_in;
            if (cons) begin
                checkOutput($sformatf("n1_data_w%0d", out_idx), bus1.data_out, words[out_idx]);
                checkOutput($sformatf("n1_first_w%0d", out_idx), bus1.first_out, 1'b1);
                checkOutput($sformatf("n1_last_w%0d", out_idx), bus1.last_out, 1'b1);
                out_idx++;
            end
            cycle();
            if (acc) begin
                in_idx++;
                if (in_idx < 5) bus1.packet_in = words[in_idx];
                else            bus1.access_in = 1'b0;
            end
        end
        bus1.wait_in = 1'b0;
        checkOutput("n1_word_count", 128'(out_idx), 128'd5);
        cycle();
        checkOutput("n1_drained", bus1.access_out, 1'b0);

        // Scoreboard soak with random upstream gaps and downstream stalls
        $display("[TB] scoreboard soak");
        have_pkt = 1'b0;
        tx_count = 0;
        rx_count = 0;
        rx_beat  = 0;
        rx       = '0;
        applyStimulus(1'b0, '0, 1'b0);
        for (cyc = 0; cyc < SOAK_LIMIT && rx_count < SOAK_PKTS; cyc++) begin
            if (!have_pkt && tx_count < SOAK_PKTS && $urandom_range(0, 3) != 0) begin
                bus.packet_in = {8'($urandom), $urandom, $urandom, $urandom};
                bus.access_in = 1'b1;
                have_pkt = 1'b1;
            end
            bus.wait_in = ($urandom_range(0, 3) == 0);
            #1;
            acc  = bus.access_in & ~bus.wait_out;
            cons = bus.access_out & ~bus.wait_in;
            if (acc) sent.push_back(bus.packet_in);
            if (cons) begin
                rx[rx_beat*32 +: 32] = bus.data_out;
                checkOutput("soak_first", bus.first_out, rx_beat == 0);
                checkOutput("soak_last",  bus.last_out,  rx_beat == 3);
                if (rx_beat == 3) begin
                    exp_pkt = (sent.size() > 0) ? {24'h0, sent.pop_front()} : '1;
                    checkOutput($sformatf("soak_pkt%0d", rx_count), rx, exp_pkt);
                    rx_count++;
                    rx_beat = 0;
                end else begin
                    rx_beat++;
                end
            end
            cycle();
            if (acc) begin
                have_pkt = 1'b0;
                tx_count++;
                bus.access_in = 1'b0;
            end
        end
        checkOutput("soak_pkt_count", 128'(rx_count), 128'(SOAK_PKTS));
        checkOutput("soak_leftover", 128'(sent.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
